// File: rtl/ram_v2.sv
// Single-port synchronous RAM with byte-lane writes, post-reset init sweep and sticky errors.
// Latency: read data valid 1 cycle after accept (rsp_valid rises on the accept edge); writes give no response.
// Backpressure: one response outstanding; req_ready = !rsp_valid || rsp_ready once init is done.
//
// Ports:
//   clk, rst (async active-low)
//   req_valid/req_ready/req_we/req_addr/req_wdata/req_be : request handshake
//   rsp_valid/rsp_ready/rsp_rdata                         : read response handshake
//   init_done                                             : init sweep complete
//   err_clr, ram_error_vector                             : sticky error flags [0]=oor [1]=parity [2]=empty be
//   parity_inject                                         : only when RAM_V2_PARITY_EN is defined
// Optional feature macro: RAM_V2_PARITY_EN (per-lane even parity storage and checking).
module ram_v2 #(
  parameter int addr_width = 10,
  parameter int data_width = 32,
  parameter int depth      = 1024,
  parameter logic [data_width-1:0] init_value = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [addr_width-1:0]   req_addr,
  input  logic [data_width-1:0]   req_wdata,
  input  logic [data_width/8-1:0] req_be,
`ifdef RAM_V2_PARITY_EN
  input  logic                    parity_inject,
`endif
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [data_width-1:0]   rsp_rdata,
  output logic                    init_done,
  input  logic                    err_clr,
  output logic [7:0]              ram_error_vector
);

  localparam int nb = data_width / 8;
  localparam logic [addr_width-1:0] last_addr = addr_width'(depth - 1);
  localparam logic [addr_width:0]   depth_w   = (addr_width + 1)'(depth);

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t                state_q, state_d;
  logic [addr_width-1:0] ptr_q;
  logic [data_width-1:0] mem [depth];

  logic acc, wr_acc, rd_acc, in_range;
  logic [2:0] err_new;

  assign in_range  = {1'b0, req_addr} < depth_w;
  assign acc       = req_valid && req_ready;
  assign wr_acc    = acc && req_we;
  assign rd_acc    = acc && !req_we;
  assign init_done = (state_q == S_READY);
  assign req_ready = (state_q == S_READY) && (!rsp_valid || rsp_ready);

`ifdef RAM_V2_PARITY_EN
  logic [nb-1:0] par [depth];
  logic          par_err;

  // Even parity per lane: stored bit equals XOR of the lane's data bits.
  function automatic logic [nb-1:0] lane_par(input logic [data_width-1:0] d);
    logic [nb-1:0] p;
    for (int i = 0; i < nb; i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction

  assign par_err = rd_acc && in_range && (lane_par(mem[req_addr]) != par[req_addr]);
`endif

  always_comb begin
    state_d = state_q;
    if (state_q == S_INIT && ptr_q == last_addr) state_d = S_READY;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_INIT && ptr_q != last_addr) ptr_q <= ptr_q + 1'b1;
    end
  end

  // Storage is never reset; the init sweep is what gives it a defined value.
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      mem[ptr_q] <= init_value;
`ifdef RAM_V2_PARITY_EN
      par[ptr_q] <= lane_par(init_value);
`endif
    end else if (wr_acc && in_range) begin
      for (int i = 0; i < nb; i++) begin
        if (req_be[i]) begin
          mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
`ifdef RAM_V2_PARITY_EN
          par[req_addr][i] <= (^req_wdata[8*i +: 8]) ^ parity_inject;
`endif
        end
      end
    end
  end

  always_comb begin
    err_new    = '0;
    err_new[0] = acc && !in_range;
`ifdef RAM_V2_PARITY_EN
    err_new[1] = par_err;
`endif
    err_new[2] = wr_acc && (req_be == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid        <= 1'b0;
      rsp_rdata        <= '0;
      ram_error_vector <= '0;
    end else begin
      if (rd_acc) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= in_range ? mem[req_addr] : '0;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      // A new error on the clearing edge survives the clear.
      if (err_clr) ram_error_vector <= {5'b0, err_new};
      else         ram_error_vector <= ram_error_vector | {5'b0, err_new};
    end
  end

endmodule

// File: tb/tb_ram_v2.sv
module tb_ram_v2;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam logic [DW-1:0] INIT = 32'h0BAD_F00D;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [3:0]    req_be = '0;
  logic          parity_inject = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic          err_clr = 1'b0;
  logic [7:0]    ram_error_vector;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_v2 #(.addr_width(AW), .data_width(DW), .depth(DEPTH), .init_value(INIT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
`ifdef RAM_V2_PARITY_EN
    .parity_inject(parity_inject),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done), .err_clr(err_clr), .ram_error_vector(ram_error_vector)
  );

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [3:0] be);
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_be = be;
  endtask

  // Releases reset at a falling edge and counts rising edges until init_done.
  task automatic release_and_count(input string name);
    int n;
    n = 0;
    @(negedge clk); rst = 1'b1;
    while (!init_done && n < 40) begin
      cyc(); n++;
      if (!init_done) begin
        n_checks++;
        if (req_ready !== 1'b0) begin
          n_fail++; $display("FAIL %s_rdy_during_init: cycle %0d req_ready=%b required 0", name, n, req_ready);
        end
      end
    end
    n_checks++;
    if (n !== DEPTH) begin
      n_fail++; $display("FAIL %s_init_cycles: got %0d required %0d", name, n, DEPTH);
    end
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({rsp_valid, req_ready, init_done, rsp_rdata, ram_error_vector} !== {3'b000, 32'h0, 8'h0}) begin
      n_fail++; $display("FAIL reset_values: vld=%b rdy=%b done=%b rdata=%h err=%h required all 0",
                         rsp_valid, req_ready, init_done, rsp_rdata, ram_error_vector);
    end
    release_and_count("reset");
  endtask

  task automatic test_init_values();
    rsp_ready = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b1, 1'b0, AW'(a), '0, 4'h0);
      cyc();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== INIT) begin
        n_fail++; $display("FAIL init_value[%0d]: vld=%b rdata=%h required 1/%h", a, rsp_valid, rsp_rdata, INIT);
      end
    end
    drive(1'b0, 1'b0, '0, '0, 4'h0);
    cyc();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL init_rsp_drain: rsp_valid=%b required 0", rsp_valid);
    end
  endtask

  task automatic test_byte_enable();
    rsp_ready = 1'b1;
    drive(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 4'b1111); cyc();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL write_no_rsp: rsp_valid=%b required 0", rsp_valid);
    end
    drive(1'b1, 1'b1, 5'd5, 32'h1122_3344, 4'b0101); cyc();
    drive(1'b1, 1'b0, 5'd5, '0, 4'h0); cyc();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDE22_BE44) begin
      n_fail++; $display("FAIL byte_enable: vld=%b rdata=%h required 1/de22be44", rsp_valid, rsp_rdata);
    end
    drive(1'b0, 1'b0, '0, '0, 4'h0); cyc();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp [4];
    exp[1] = 32'h1111_0001; exp[2] = 32'h2222_0002; exp[3] = 32'h3333_0003;
    rsp_ready = 1'b1;
    for (int a = 1; a <= 3; a++) begin
      drive(1'b1, 1'b1, AW'(a), exp[a], 4'hF); cyc();
    end
    for (int a = 1; a <= 3; a++) begin
      drive(1'b1, 1'b0, AW'(a), '0, 4'h0); cyc();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp[a]) begin
        n_fail++; $display("FAIL b2b_read[%0d]: vld=%b rdata=%h required 1/%h", a, rsp_valid, rsp_rdata, exp[a]);
      end
    end
    rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 5'd1, '0, 4'h0);
    #1;
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_fail++; $display("FAIL stall_rdy: req_ready=%b required 0", req_ready);
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp[3] || req_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold[%0d]: vld=%b rdata=%h rdy=%b required 1/%h/0",
                           k, rsp_valid, rsp_rdata, req_ready, exp[3]);
      end
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL release_rdy: req_ready=%b required 1", req_ready);
    end
    cyc();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== exp[1]) begin
      n_fail++; $display("FAIL release_read: vld=%b rdata=%h required 1/%h", rsp_valid, rsp_rdata, exp[1]);
    end
    drive(1'b0, 1'b0, '0, '0, 4'h0); cyc();
  endtask

  task automatic test_errors();
    rsp_ready = 1'b1;
    n_checks++;
    if (ram_error_vector !== 8'h00) begin
      n_fail++; $display("FAIL err_clean: err=%h required 00", ram_error_vector);
    end
    drive(1'b1, 1'b0, 5'd20, '0, 4'h0); cyc();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || ram_error_vector !== 8'h01) begin
      n_fail++; $display("FAIL oor_read: vld=%b rdata=%h err=%h required 1/00000000/01",
                         rsp_valid, rsp_rdata, ram_error_vector);
    end
    drive(1'b1, 1'b1, 5'd2, 32'hFFFF_FFFF, 4'h0); cyc();
    n_checks++;
    if (ram_error_vector !== 8'h05) begin
      n_fail++; $display("FAIL empty_be: err=%h required 05", ram_error_vector);
    end
    drive(1'b1, 1'b0, 5'd2, '0, 4'h0); cyc();
    n_checks++;
    if (rsp_rdata !== 32'h2222_0002) begin
      n_fail++; $display("FAIL empty_be_nochange: rdata=%h required 22220002", rsp_rdata);
    end
    drive(1'b0, 1'b0, '0, '0, 4'h0); err_clr = 1'b1; cyc();
    n_checks++;
    if (ram_error_vector !== 8'h00) begin
      n_fail++; $display("FAIL err_clr: err=%h required 00", ram_error_vector);
    end
    drive(1'b1, 1'b1, 5'd25, 32'h1234_5678, 4'hF); cyc();
    n_checks++;
    if (ram_error_vector !== 8'h01) begin
      n_fail++; $display("FAIL clr_vs_new: err=%h required 01", ram_error_vector);
    end
    err_clr = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 4'h0); cyc();
    n_checks++;
    if (ram_error_vector !== 8'h01) begin
      n_fail++; $display("FAIL err_sticky: err=%h required 01", ram_error_vector);
    end
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 5'd1, '0, 4'h0); cyc();
    drive(1'b0, 1'b0, '0, '0, 4'h0);
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_pending: rsp_valid=%b required 1", rsp_valid);
    end
    rst = 1'b0; #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || init_done !== 1'b0 || rsp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset: vld=%b rdy=%b done=%b rdata=%h required 0/0/0/0",
                         rsp_valid, req_ready, init_done, rsp_rdata);
    end
    release_and_count("mid_reset");
    for (int k = 0; k < 5; k++) cyc();
    n_checks++;
    if (init_done !== 1'b1) begin
      n_fail++; $display("FAIL stay_ready: init_done=%b required 1", init_done);
    end
    @(negedge clk); rst = 1'b0;
    cyc(); cyc();
    @(negedge clk); rst = 1'b1;
    for (int k = 0; k < 5; k++) cyc();
    rst = 1'b0; #1;
    n_checks++;
    if (init_done !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL init_reset: done=%b vld=%b required 0/0", init_done, rsp_valid);
    end
    release_and_count("sweep_restart");
    rsp_ready = 1'b1;
    drive(1'b1, 1'b0, 5'd5, '0, 4'h0); cyc();
    n_checks++;
    if (rsp_rdata !== INIT) begin
      n_fail++; $display("FAIL reinit_value: rdata=%h required %h", rsp_rdata, INIT);
    end
    drive(1'b0, 1'b0, '0, '0, 4'h0); cyc();
  endtask

`ifdef RAM_V2_PARITY_EN
  task automatic test_parity();
    rsp_ready = 1'b1;
    parity_inject = 1'b1;
    drive(1'b1, 1'b1, 5'd3, 32'hCAFE_0123, 4'hF); cyc();
    parity_inject = 1'b0;
    drive(1'b1, 1'b0, 5'd3, '0, 4'h0); cyc();
    n_checks++;
    if (rsp_rdata !== 32'hCAFE_0123 || ram_error_vector !== 8'h02) begin
      n_fail++; $display("FAIL parity_inject: rdata=%h err=%h required cafe0123/02", rsp_rdata, ram_error_vector);
    end
    drive(1'b0, 1'b0, '0, '0, 4'h0); err_clr = 1'b1; cyc(); err_clr = 1'b0;
    drive(1'b1, 1'b1, 5'd4, 32'h5A5A_A5A5, 4'hF); cyc();
    drive(1'b1, 1'b0, 5'd4, '0, 4'h0); cyc();
    n_checks++;
    if (rsp_rdata !== 32'h5A5A_A5A5 || ram_error_vector !== 8'h00) begin
      n_fail++; $display("FAIL parity_clean: rdata=%h err=%h required 5a5aa5a5/00", rsp_rdata, ram_error_vector);
    end
    drive(1'b0, 1'b0, '0, '0, 4'h0); cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_init_values();
    test_byte_enable();
    test_back_to_back();
    test_errors();
`ifdef RAM_V2_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
